alu_operand_loader: RTL and testbench

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_operand_loader.sv | 106 ++++++++++
 tb/tb_alu_operand_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: datapath widths and FSM states.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_operand_loader.sv
// Serial operand loader for an external 8-bit ALU: collects A, B and an op
// byte from a byte stream, holds them stable for one execute cycle, captures
// the ALU result and presents it until acknowledged. A set chain bit reuses
// the previous result as the next A operand.
module alu_operand_loader
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res_out,
  output logic              res_valid,
  input  logic              res_ack,
  output logic              chain
);

  state_e              state_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [SEL_W-1:0]    sel_q;
  logic                chain_q;
  logic [DATA_W-1:0]   res_q;
  logic                res_valid_q;
  logic                in_load;

  // Byte acceptance is only possible in the three load states while enabled.
  always_comb begin
    in_load = 1'b0;
    case (state_q)
      LOAD_A, LOAD_B, LOAD_OP: in_load = 1'b1;
      default:                 in_load = 1'b0;
    endcase
  end

  assign din_ready = in_load & ena;

  // Loader FSM with all operand/result registers; everything freezes when ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      chain_q     <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else if (ena) begin
      case (state_q)
        LOAD_A: begin
          if (din_valid) begin
            a_q     <= din;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (din_valid) begin
            b_q     <= din;
            state_q <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (din_valid) begin
            sel_q   <= din[SEL_W-1:0];
            chain_q <= din[2];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= alu_result;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (res_ack) begin
            res_valid_q <= 1'b0;
            if (chain_q) begin
              a_q     <= res_q;
              state_q <= LOAD_B;
            end else begin
              state_q <= LOAD_A;
            end
          end
        end
        default: begin
          state_q     <= LOAD_A;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign chain     = chain_q;
  assign res_out   = res_q;
  assign res_valid = res_valid_q;

endmodule : alu_operand_loader

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small combinational ALU model.
module tb_alu_operand_loader;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic [7:0] res_out;
  logic       res_valid;
  logic       res_ack;
  logic       chain;

  int unsigned n_cmp;
  int unsigned n_bad;

  alu_operand_loader dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .res_out    (res_out),
    .res_valid  (res_valid),
    .res_ack    (res_ack),
    .chain      (chain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 add, 2 subtract, 3 xor.
  always_comb begin
    case (alu_sel)
      2'd0:    alu_result = alu_a + alu_b;
      2'd1:    alu_result = alu_a + alu_b;
      2'd2:    alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; ena = 1'b1; din = 8'h00; din_valid = 1'b0; res_ack = 1'b0;

    // Reset state
    tick();
    check("rst_a", alu_a, 8'h00);
    check("rst_b", alu_b, 8'h00);
    check("rst_res", res_out, 8'h00);
    check("rst_sel", {6'd0, alu_sel}, 8'h00);
    check("rst_chain", {7'd0, chain}, 8'h00);
    check("rst_rv", {7'd0, res_valid}, 8'h00);
    rst = 1'b0;
    #1;
    check("rst_ready", {7'd0, din_ready}, 8'h01);

    // Basic op: 0x12 + 0x34
    din = 8'h12; din_valid = 1'b1; tick();
    check("basic_a", alu_a, 8'h12);
    din = 8'h34; tick();
    check("basic_b", alu_b, 8'h34);
    din = 8'h01; tick();
    check("basic_sel", {6'd0, alu_sel}, 8'h01);
    check("basic_exec_ready", {7'd0, din_ready}, 8'h00);
    check("basic_exec_rv", {7'd0, res_valid}, 8'h00);
    din_valid = 1'b0; tick();
    check("basic_rv", {7'd0, res_valid}, 8'h01);
    check("basic_res", res_out, 8'h46);

    // Backpressure: ack held low, stray din_valid must not be consumed
    din = 8'h99;
    for (int i = 0; i < 10; i++) begin
      din_valid = (i == 3 || i == 4);
      tick();
      check("bp_rv", {7'd0, res_valid}, 8'h01);
      check("bp_res", res_out, 8'h46);
      check("bp_ready", {7'd0, din_ready}, 8'h00);
      check("bp_a", alu_a, 8'h12);
    end
    din_valid = 1'b0; res_ack = 1'b1; tick();
    check("bp_ack_rv", {7'd0, res_valid}, 8'h00);
    check("bp_ack_ready", {7'd0, din_ready}, 8'h01);
    res_ack = 1'b0;

    // Chaining: op 0x04 then only B and op bytes
    din_valid = 1'b1;
    din = 8'h12; tick();
    din = 8'h34; tick();
    din = 8'h04; tick();
    check("ch_chain", {7'd0, chain}, 8'h01);
    check("ch_sel", {6'd0, alu_sel}, 8'h00);
    din_valid = 1'b0; tick();
    check("ch_res", res_out, 8'h46);
    res_ack = 1'b1; tick();
    res_ack = 1'b0;
    check("ch_ack_rv", {7'd0, res_valid}, 8'h00);
    check("ch_a_from_res", alu_a, 8'h46);
    check("ch_ready_b", {7'd0, din_ready}, 8'h01);
    din_valid = 1'b1; din = 8'h10; tick();
    check("ch_b", alu_b, 8'h10);
    check("ch_a_kept", alu_a, 8'h46);
    din = 8'h00; tick();
    check("ch2_chain", {7'd0, chain}, 8'h00);
    din_valid = 1'b0; tick();
    check("ch2_res", res_out, 8'h56);
    res_ack = 1'b1; tick();
    res_ack = 1'b0;
    check("ch2_ack_ready", {7'd0, din_ready}, 8'h01);

    // ena gap between B and op byte
    din_valid = 1'b1;
    din = 8'h12; tick();
    din = 8'h34; tick();
    din = 8'h01; ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_ready", {7'd0, din_ready}, 8'h00);
      check("gap_sel", {6'd0, alu_sel}, 8'h00);
      check("gap_b", alu_b, 8'h34);
      check("gap_rv", {7'd0, res_valid}, 8'h00);
    end
    ena = 1'b1; tick();
    check("gap_sel_loaded", {6'd0, alu_sel}, 8'h01);
    din_valid = 1'b0; tick();
    check("gap_res", res_out, 8'h46);
    check("gap_rv_done", {7'd0, res_valid}, 8'h01);
    // ena low in DONE freezes the ack
    ena = 1'b0; res_ack = 1'b1; tick();
    check("gap_done_frozen", {7'd0, res_valid}, 8'h01);
    ena = 1'b1; tick();
    res_ack = 1'b0;
    check("gap_done_ack", {7'd0, res_valid}, 8'h00);

    // Reset mid-load discards A
    din_valid = 1'b1; din = 8'hFF; tick();
    check("mid_a_ff", alu_a, 8'hFF);
    rst = 1'b1; din_valid = 1'b0; tick();
    rst = 1'b0;
    check("mid_rst_a", alu_a, 8'h00);
    check("mid_rst_ready", {7'd0, din_ready}, 8'h01);

    // Bit masking, with res_ack high outside DONE
    res_ack = 1'b1;
    din_valid = 1'b1; din = 8'h21; tick();
    check("mask_a", alu_a, 8'h21);
    din = 8'h03; tick();
    check("mask_b", alu_b, 8'h03);
    din = 8'hFB; tick();
    check("mask_sel", {6'd0, alu_sel}, 8'h03);
    check("mask_chain", {7'd0, chain}, 8'h00);
    din_valid = 1'b0; tick();
    check("mask_rv", {7'd0, res_valid}, 8'h01);
    check("mask_res", res_out, 8'h22);
    tick();
    res_ack = 1'b0;
    check("mask_ack_rv", {7'd0, res_valid}, 8'h00);
    check("mask_ack_a", alu_a, 8'h21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_operand_loader
